// File: rtl/vga_timing_pkg.sv
// Raster timing constants for 640x480@60 and a small range-decode helper.
package vga_timing_pkg;
  localparam int COORD_W  = 10;
  localparam int FCNT_W   = 8;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // True when pos lies in the inclusive window [lo, hi].
  function automatic logic in_range(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos <= hi);
  endfunction
endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Clock divider producing one enable pulse per pixel period.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  // Count 0..CLK_DIV-1 while enabled; hold otherwise.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  // With CLK_DIV=1 the counter stays at 0 and tick simply follows en.
  assign tick = en && (div_cnt_q == LAST);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel tick, h/v counters, registered sync/active
// decode, line/frame markers and a wrapping frame counter.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACT    = H_ACTIVE,
  parameter int   H_FPW    = H_FP,
  parameter int   H_SYNCW  = H_SYNC,
  parameter int   H_BPW    = H_BP,
  parameter int   V_ACT    = V_ACTIVE,
  parameter int   V_FPW    = V_FP,
  parameter int   V_SYNCW  = V_SYNC,
  parameter int   V_BPW    = V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pix_tick,
  output logic [COORD_W-1:0] xcoor,
  output logic [COORD_W-1:0] ycoor,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FCNT_W-1:0]  frame_cnt
);
  localparam int HT      = H_ACT + H_FPW + H_SYNCW + H_BPW;
  localparam int VT      = V_ACT + V_FPW + V_SYNCW + V_BPW;
  localparam int HS_LO   = H_ACT + H_FPW;
  localparam int HS_HI   = H_ACT + H_FPW + H_SYNCW - 1;
  localparam int VS_LO   = V_ACT + V_FPW;
  localparam int VS_HI   = V_ACT + V_FPW + V_SYNCW - 1;

  logic tick;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // h_cnt/v_cnt hold the position presented on the next tick.
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] xcoor_q, xcoor_d, ycoor_q, ycoor_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // On each tick register the decode of (h_cnt,v_cnt) and advance the raster;
  // pulses fall back to 0 on every non-tick clock (including while disabled).
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    xcoor_d       = xcoor_q;
    ycoor_d       = ycoor_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      xcoor_d       = h_cnt_q;
      ycoor_d       = v_cnt_q;
      active_d      = (int'(h_cnt_q) < H_ACT) && (int'(v_cnt_q) < V_ACT);
      hsync_d       = in_range(int'(h_cnt_q), HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = in_range(int'(v_cnt_q), VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      if (frame_start_d) frame_cnt_d = frame_cnt_q + 8'd1;
      if (int'(h_cnt_q) == HT - 1) begin
        h_cnt_d = '0;
        v_cnt_d = (int'(v_cnt_q) == VT - 1) ? '0 : v_cnt_q + COORD_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + COORD_W'(1);
      end
    end
  end

  // Raster and output registers; reset parks sync lines at their idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      xcoor_q       <= '0;
      ycoor_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      xcoor_q       <= xcoor_d;
      ycoor_q       <= ycoor_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_tick    = tick;
  assign xcoor       = xcoor_q;
  assign ycoor       = ycoor_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken raster (12x8 total) so that whole
// frames and the 8-bit frame counter wrap fit in a short run.
module tb_vga_sync_gen;
  localparam int DIV = 2;
  localparam int HA = 6, HF = 1, HS = 2, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  logic clk = 1'b0;
  logic rst, en;
  logic pix_tick, hsync, vsync, active, line_start, frame_start;
  logic [9:0] xcoor, ycoor;
  logic [7:0] frame_cnt;
  logic pix_tick1, hsync1, vsync1, active1, line_start1, frame_start1;
  logic [9:0] xcoor1, ycoor1;
  logic [7:0] frame_cnt1;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(DIV), .H_ACT(HA), .H_FPW(HF), .H_SYNCW(HS), .H_BPW(HB),
    .V_ACT(VA), .V_FPW(VF), .V_SYNCW(VS), .V_BPW(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_tick(pix_tick), .xcoor(xcoor),
    .ycoor(ycoor), .hsync(hsync), .vsync(vsync), .active(active),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .pix_tick(pix_tick1), .xcoor(xcoor1),
    .ycoor(ycoor1), .hsync(hsync1), .vsync(vsync1), .active(active1),
    .line_start(line_start1), .frame_start(frame_start1), .frame_cnt(frame_cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mdiv = 0, mh = 0, mv = 0;
  out_t held;
  out_t exp_q[$];

  function automatic out_t reset_vals();
    out_t r;
    r = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  function automatic out_t dut_out();
    return '{pix_tick, xcoor, ycoor, hsync, vsync, active, line_start, frame_start, frame_cnt};
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Predict the outputs after the coming edge, queue them, clock, then compare.
  task automatic step(input string tag);
    out_t e, got;
    if (rst) begin
      mdiv = 0; mh = 0; mv = 0;
      held = reset_vals();
    end else begin
      held.ls = 1'b0;
      held.fs = 1'b0;
      if (en) begin
        if (mdiv == DIV - 1) begin
          held.x   = 10'(mh);
          held.y   = 10'(mv);
          held.act = (mh < HA) && (mv < VA);
          held.hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
          held.vs  = !((mv >= VA + VF) && (mv < VA + VF + VS));
          held.ls  = (mh == 0);
          held.fs  = (mh == 0) && (mv == 0);
          if (held.fs) held.fc = held.fc + 8'd1;
          mh = mh + 1;
          if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
          end
        end
        mdiv = (mdiv == DIV - 1) ? 0 : mdiv + 1;
      end
    end
    e = held;
    e.tick = en && !rst && (mdiv == DIV - 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = dut_out();
    e = exp_q.pop_front();
    n_tests++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, e);
    end
    if (!rst) chk("div1_tick", int'(pix_tick1), int'(en));
  endtask

  int hs_low, vs_low, fs_cyc;
  bit saw255, found;
  out_t snap;

  initial begin
    held = reset_vals();
    rst = 1'b1;
    en  = 1'b1;
    // Reset held for three clocks.
    repeat (3) step("reset");
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_vsync", int'(vsync), 1);
    chk("reset_fcnt", int'(frame_cnt), 0);

    // Release; first tick presents (0,0).
    rst = 1'b0;
    step("first_tick");
    chk("tick_after_release", int'(pix_tick), 1);
    step("first_pixel");
    fs_cyc = cyc;
    chk("first_x", int'(xcoor), 0);
    chk("first_active", int'(active), 1);
    chk("first_fs", int'(frame_start), 1);
    chk("first_ls", int'(line_start), 1);
    chk("first_fcnt", int'(frame_cnt), 1);

    // Line 0 through the wrap onto line 1.
    hs_low = 0;
    for (int i = 0; i < 4 * HT; i++) begin
      step("line0");
      if (hsync === 1'b0) hs_low++;
      if (line_start === 1'b1) break;
    end
    chk("hsync_low_clks", hs_low, HS * DIV);
    chk("line1_x", int'(xcoor), 0);
    chk("line1_y", int'(ycoor), 1);
    chk("line1_ls", int'(line_start), 1);
    chk("line1_fs", int'(frame_start), 0);

    // Rest of the frame up to the next frame_start.
    vs_low = 0;
    for (int i = 0; i < 2 * HT * VT * DIV; i++) begin
      step("frame");
      if (vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) break;
    end
    chk("vsync_low_clks", vs_low, VS * HT * DIV);
    chk("frame_period", cyc - fs_cyc, HT * VT * DIV);
    chk("frame2_fcnt", int'(frame_cnt), 2);

    // Frame counter wraps 255 -> 0.
    saw255 = 0;
    for (int i = 0; i < 256 * HT * VT * DIV; i++) begin
      step("wrap");
      if (frame_start === 1'b1 && frame_cnt === 8'd255) saw255 = 1;
      if (frame_cnt === 8'd0) break;
    end
    chk("saw_fcnt_255", int'(saw255), 1);
    chk("wrap_fcnt", int'(frame_cnt), 0);
    chk("wrap_fs", int'(frame_start), 1);

    // Freeze at (3,2) for 50 clocks, then resume.
    found = 0;
    for (int i = 0; i < 2 * HT * VT * DIV; i++) begin
      step("seek_freeze");
      if (xcoor === 10'd3 && ycoor === 10'd2) begin found = 1; break; end
    end
    chk("freeze_found", int'(found), 1);
    snap = dut_out();
    en = 1'b0;
    repeat (50) step("frozen");
    chk("frozen_outputs", int'(dut_out() === snap), 1);
    en = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) begin
      step("resume");
      if (xcoor !== 10'd3) break;
    end
    chk("resume_x", int'(xcoor), 4);
    chk("resume_y", int'(ycoor), 2);

    // Reset mid-frame at (8,6) with both syncs asserted.
    found = 0;
    for (int i = 0; i < 2 * HT * VT * DIV; i++) begin
      step("seek_reset");
      if (xcoor === 10'd8 && ycoor === 10'd6) begin found = 1; break; end
    end
    chk("reset_pt_found", int'(found), 1);
    chk("pre_reset_hsync", int'(hsync), 0);
    chk("pre_reset_vsync", int'(vsync), 0);
    rst = 1'b1;
    #1;
    chk("async_rst_x", int'(xcoor), 0);
    chk("async_rst_hsync", int'(hsync), 1);
    chk("async_rst_vsync", int'(vsync), 1);
    chk("async_rst_fcnt", int'(frame_cnt), 0);
    step("mid_reset");
    rst = 1'b0;
    step("restart_tick");
    step("restart_pixel");
    chk("restart_fs", int'(frame_start), 1);
    chk("restart_fcnt", int'(frame_cnt), 1);
    chk("restart_xy", int'({xcoor, ycoor}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
